// File: rtl/ddr_burst_if.sv
// ---------------------------------------------------------------------------
// ddr_burst_if
//   Burst request bus between the DDR address/control logic (master) and the
//   memory side (slave).
//
//   burstbegin  m->s  first beat of a request
//   write_req   m->s  write beat valid, w_data consumed when high
//   read_req    m->s  read burst request, sampled with burstbegin
//   addr        m->s  word address of beat 0, sampled with burstbegin
//   w_data      m->s  write beat data
//   r_data      s->m  read beat data
//   rdata_vaild s->m  r_data valid, one cycle per beat
//   ready       s->m  slave idle, a new burst may start
//   wr_done     s->m  one-cycle pulse after the last write beat is stored
//   proto_err   s->m  sticky protocol-error flag
// ---------------------------------------------------------------------------
interface ddr_burst_if #(
  parameter int ADDR_W = 10
);
  logic              burstbegin;
  logic              write_req;
  logic              read_req;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       w_data;
  logic [15:0]       r_data;
  logic              rdata_vaild;
  logic              ready;
  logic              wr_done;
  logic              proto_err;

  modport master (
    output burstbegin, write_req, read_req, addr, w_data,
    input  r_data, rdata_vaild, ready, wr_done, proto_err
  );

  modport slave (
    input  burstbegin, write_req, read_req, addr, w_data,
    output r_data, rdata_vaild, ready, wr_done, proto_err
  );
endinterface

// File: rtl/ddr_burst_responder.sv
// ---------------------------------------------------------------------------
// ddr_burst_responder
//   On-chip stand-in for the external DDR: a 2^ADDR_W x 16-bit word array
//   answering BURST_LEN-beat write and read bursts, with a fixed read
//   latency of RD_LAT cycles, back-pressure via ready and a sticky
//   protocol-error flag.
//
//   clk_150_0  in   system clock, rising edge
//   reset_syn  in   asynchronous, active-high reset
//   bus        slave modport of ddr_burst_if (requests in, read data,
//                   rdata_vaild, ready, wr_done, proto_err out)
// ---------------------------------------------------------------------------
module ddr_burst_responder #(
  parameter int ADDR_W    = 10,
  parameter int BURST_LEN = 8,
  parameter int RD_LAT    = 2
) (
  input  logic        clk_150_0,
  input  logic        reset_syn,
  ddr_burst_if.slave  bus
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_WAIT,
    RD_BURST
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [15:0]       r_data_q, r_data_d;
  logic              rdata_vaild_q, rdata_vaild_d;
  logic              wr_done_q, wr_done_d;
  logic              proto_err_q, proto_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic [ADDR_W-1:0] beat_addr;

  logic [15:0] mem [2**ADDR_W];

  // Truncation to ADDR_W bits makes bursts wrap past the top of the array.
  assign beat_addr = base_q + ADDR_W'(cnt_q);

  // NOTE: every signal gets a default at the top of always_comb, so no path
  // leaves it unassigned and no latch is inferred; blocking '=' is correct
  // here because this block describes combinational logic only.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    cnt_d         = cnt_q;
    lat_d         = lat_q;
    r_data_d      = r_data_q;
    rdata_vaild_d = 1'b0;
    wr_done_d     = 1'b0;
    proto_err_d   = proto_err_q;
    mem_we        = 1'b0;
    mem_waddr     = beat_addr;
    mem_wdata     = bus.w_data;

    unique case (state_q)
      IDLE: begin
        if (bus.burstbegin) begin
          if (bus.write_req) begin
            // A write wins over a simultaneous read; the clash is flagged.
            if (bus.read_req) proto_err_d = 1'b1;
            base_d    = bus.addr;
            mem_we    = 1'b1;
            mem_waddr = bus.addr;
            if (LAST_BEAT == '0) begin
              wr_done_d = 1'b1;
              cnt_d     = '0;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = WR_BURST;
            end
          end else if (bus.read_req) begin
            base_d  = bus.addr;
            cnt_d   = '0;
            lat_d   = LAT_INIT;
            state_d = RD_WAIT;
          end else begin
            proto_err_d = 1'b1;
          end
        end
      end

      WR_BURST: begin
        if (bus.burstbegin) proto_err_d = 1'b1;
        // write_req low is a stall: nothing consumed, no timeout.
        if (bus.write_req) begin
          mem_we = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            wr_done_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RD_WAIT: begin
        if (bus.burstbegin) proto_err_d = 1'b1;
        if (lat_q == '0) begin
          // cnt_q is 0 here, so beat_addr is base: beat 0 leaves now.
          r_data_d      = mem[beat_addr];
          rdata_vaild_d = 1'b1;
          if (LAST_BEAT == '0) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = RD_BURST;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      RD_BURST: begin
        if (bus.burstbegin) proto_err_d = 1'b1;
        r_data_d      = mem[beat_addr];
        rdata_vaild_d = 1'b1;
        // Leaving on the last beat puts ready back up while that beat is
        // still valid, so the next burst can start without a dead cycle.
        if (cnt_q == LAST_BEAT) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_150_0 or posedge reset_syn) begin
    if (reset_syn) begin
      state_q       <= IDLE;
      base_q        <= '0;
      cnt_q         <= '0;
      lat_q         <= '0;
      r_data_q      <= '0;
      rdata_vaild_q <= 1'b0;
      wr_done_q     <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      cnt_q         <= cnt_d;
      lat_q         <= lat_d;
      r_data_q      <= r_data_d;
      rdata_vaild_q <= rdata_vaild_d;
      wr_done_q     <= wr_done_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // NOTE: the array has no reset on purpose; contents must survive a reset
  // mid-burst, and a resettable array could not map onto block RAM.
  always_ff @(posedge clk_150_0) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.r_data      = r_data_q;
  assign bus.rdata_vaild = rdata_vaild_q;
  assign bus.ready       = (state_q == IDLE);
  assign bus.wr_done     = wr_done_q;
  assign bus.proto_err   = proto_err_q;

endmodule

// File: tb/tb_ddr_burst_responder.sv
`timescale 1ns/1ps
module tb_ddr_burst_responder;

  localparam int ADDR_W    = 10;
  localparam int BURST_LEN = 8;
  localparam int RD_LAT    = 2;

  logic clk_150_0 = 1'b0;
  logic reset_syn;

  always #3 clk_150_0 = ~clk_150_0;

  ddr_burst_if #(.ADDR_W(ADDR_W)) bus ();

  ddr_burst_responder #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk_150_0 (clk_150_0),
    .reset_syn (reset_syn),
    .bus       (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Bench-side image of the array, updated only by the stimulus it drives.
  logic [15:0] model [2**ADDR_W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; all driving and sampling happen here.
  task automatic tick();
    @(posedge clk_150_0);
    #1;
  endtask

  task automatic idle_inputs();
    bus.burstbegin = 1'b0;
    bus.write_req  = 1'b0;
    bus.read_req   = 1'b0;
    bus.addr       = '0;
    bus.w_data     = '0;
  endtask

  // Write burst with data d0, d0+1, ...; optional stall of stall_n cycles
  // after beat index stall_after; with_rd also raises read_req on beat 0.
  task automatic write_burst(input logic [ADDR_W-1:0] a, input logic [15:0] d0,
                             input bit with_rd, input int stall_after,
                             input int stall_n, input string tag);
    logic [ADDR_W-1:0] wa;
    bus.burstbegin = 1'b1;
    bus.write_req  = 1'b1;
    bus.read_req   = with_rd;
    bus.addr       = a;
    bus.w_data     = d0;
    model[a]       = d0;
    tick();
    bus.burstbegin = 1'b0;
    bus.read_req   = 1'b0;
    for (int i = 1; i < BURST_LEN; i++) begin
      if (i == stall_after + 1) begin
        for (int s = 0; s < stall_n; s++) begin
          bus.write_req = 1'b0;
          tick();
          check({tag, "_stall_ready"}, bus.ready, 0);
          check({tag, "_stall_wr_done"}, bus.wr_done, 0);
        end
      end
      bus.write_req = 1'b1;
      bus.w_data    = 16'(d0 + i);
      wa            = ADDR_W'(a + i);
      model[wa]     = bus.w_data;
      check({tag, "_ready"}, bus.ready, 0);
      check({tag, "_wr_done_early"}, bus.wr_done, 0);
      check({tag, "_no_rvalid"}, bus.rdata_vaild, 0);
      tick();
    end
    bus.write_req = 1'b0;
    check({tag, "_wr_done"}, bus.wr_done, 1);
    check({tag, "_ready_back"}, bus.ready, 1);
  endtask

  // Read burst at a; expected data from the model. inject_at >= 1 drives a
  // stray read burstbegin at inj_a, sampled at edge k+inject_at.
  task automatic read_burst(input logic [ADDR_W-1:0] a, input int inject_at,
                            input logic [ADDR_W-1:0] inj_a, input string tag);
    logic exp_v;
    logic [ADDR_W-1:0] ra;
    bus.burstbegin = 1'b1;
    bus.read_req   = 1'b1;
    bus.write_req  = 1'b0;
    bus.addr       = a;
    tick();
    bus.burstbegin = 1'b0;
    bus.read_req   = 1'b0;
    check({tag, "_k_ready"}, bus.ready, 0);
    check({tag, "_k_rvalid"}, bus.rdata_vaild, 0);
    check({tag, "_wr_done_once"}, bus.wr_done, 0);
    for (int j = 1; j <= RD_LAT + BURST_LEN; j++) begin
      if (j == inject_at) begin
        bus.burstbegin = 1'b1;
        bus.read_req   = 1'b1;
        bus.addr       = inj_a;
      end
      tick();
      bus.burstbegin = 1'b0;
      bus.read_req   = 1'b0;
      exp_v = (j >= RD_LAT) && (j <= RD_LAT + BURST_LEN - 1);
      check($sformatf("%s_rvalid_k%0d", tag, j), bus.rdata_vaild, 32'(exp_v));
      if (exp_v) begin
        ra = ADDR_W'(a + j - RD_LAT);
        check($sformatf("%s_rdata_k%0d", tag, j), bus.r_data, model[ra]);
      end
      check($sformatf("%s_ready_k%0d", tag, j), bus.ready,
            32'(j >= RD_LAT + BURST_LEN - 1));
    end
  endtask

  initial begin
    idle_inputs();
    reset_syn = 1'b1;
    repeat (3) tick();
    check("rst_ready", bus.ready, 1);
    check("rst_rvalid", bus.rdata_vaild, 0);
    check("rst_rdata", bus.r_data, 0);
    check("rst_wr_done", bus.wr_done, 0);
    check("rst_proto_err", bus.proto_err, 0);
    reset_syn = 1'b0;
    tick();

    // 1: plain write, then back-to-back read of the same burst
    write_burst(10'h000, 16'h1000, 1'b0, -1, 0, "t1w");
    read_burst(10'h000, -1, '0, "t1r");

    // 2: write wrapping past the top of the array
    write_burst(10'h3FC, 16'h00A0, 1'b0, -1, 0, "t2w");
    read_burst(10'h000, -1, '0, "t2r0");
    read_burst(10'h3FC, -1, '0, "t2r3fc");

    // 3: 3-cycle stall after beat 3; neighbours must stay intact
    write_burst(10'h008, 16'h3300, 1'b0, 3, 3, "t3w");
    read_burst(10'h008, -1, '0, "t3r8");
    read_burst(10'h004, -1, '0, "t3r4");
    check("t3_no_err", bus.proto_err, 0);

    // 4: write_req and read_req together: write wins, error flagged
    write_burst(10'h040, 16'h4400, 1'b1, -1, 0, "t4w");
    check("t4_err", bus.proto_err, 1);
    read_burst(10'h040, -1, '0, "t4r");
    check("t4_err_sticky", bus.proto_err, 1);

    // 6: reset during read beat 4
    bus.burstbegin = 1'b1;
    bus.read_req   = 1'b1;
    bus.addr       = 10'h000;
    tick();
    idle_inputs();
    repeat (RD_LAT + 4) tick();
    check("t6_beat4_valid", bus.rdata_vaild, 1);
    check("t6_beat4_data", bus.r_data, model[4]);
    reset_syn = 1'b1;
    #1;
    check("t6_async_rvalid", bus.rdata_vaild, 0);
    check("t6_async_ready", bus.ready, 1);
    check("t6_async_err", bus.proto_err, 0);
    check("t6_async_rdata", bus.r_data, 0);
    tick();
    tick();
    reset_syn = 1'b0;
    tick();
    check("t6_post_ready", bus.ready, 1);
    check("t6_post_err", bus.proto_err, 0);
    check("t6_post_rvalid", bus.rdata_vaild, 0);
    read_burst(10'h000, -1, '0, "t6r");

    // 5: stray read burstbegin during an active read is ignored
    check("t5_pre_err", bus.proto_err, 0);
    read_burst(10'h000, 5, 10'h100, "t5r");
    check("t5_err", bus.proto_err, 1);
    tick();
    check("t5_no_extra_rvalid", bus.rdata_vaild, 0);
    check("t5_idle_ready", bus.ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_burst_responder.md
Name: ddr_burst_responder

Overview:
- Memory-side responder for the burst request interface driven by the DDR address/control logic (write_req, read_req, burstbegin, addr, w_data / r_data, rdata_vaild).
- Emulates the external DDR with an on-chip 16-bit word array, so the ping-pong buffering controller can be exercised and run on-chip without the DDR IP.
- Accepts 8-beat write and read bursts, adds a fixed read latency and reports back-pressure and protocol errors.

Parameters:
- ADDR_W, 10, word address width; array depth is 2^ADDR_W words of 16 bit.
- BURST_LEN, 8, beats per burst, power of two, ≤ 2^ADDR_W.
- RD_LAT, 2, cycles from the sampled read burstbegin edge to the first rdata_vaild beat, ≥ 1.

Ports:
- clk_150_0  in  1  system clock; all logic is rising-edge.
- reset_syn  in  1  asynchronous, active-high reset.
- burstbegin  in  1  first beat of a request, valid with write_req or read_req.
- write_req  in  1  write beat valid; w_data is consumed when high.
- read_req  in  1  read burst request, sampled only with burstbegin.
- addr  in  ADDR_W  word address of beat 0, sampled only with burstbegin.
- w_data  in  16  write beat data.
- r_data  out  16  read beat data, registered.
- rdata_vaild  out  1  r_data valid, one cycle per beat.
- ready  out  1  high only in IDLE; a new burst is accepted only when high.
- wr_done  out  1  one-cycle pulse after the last write beat is stored.
- proto_err  out  1  sticky protocol-error flag, cleared only by reset.

Behaviour:
- Reset (asynchronous, active-high, reset_syn; clock clk_150_0):
  - state goes to IDLE.
  - r_data=0, rdata_vaild=0, wr_done=0, proto_err=0, ready=1, beat counter=0.
  - Memory contents are not reset.
- Beat address is (base + cnt) mod 2^ADDR_W, so bursts wrap past the top of the array to address 0.
- Four states: IDLE, WR_BURST, RD_WAIT, RD_BURST.
- IDLE:
  - burstbegin & write_req: base<=addr; mem[addr]<=w_data (beat 0); cnt<=1; go to WR_BURST.
  - burstbegin & read_req & !write_req: base<=addr; cnt<=0; latency counter<=RD_LAT-1; go to RD_WAIT.
  - burstbegin & write_req & read_req: the write wins and proto_err<=1.
  - burstbegin with neither request: ignored, proto_err<=1.
  - write_req without burstbegin: ignored.
- WR_BURST:
  - Each cycle with write_req=1: mem[base+cnt]<=w_data; cnt++.
  - write_req=0 is a stall: no beat is consumed, the state is held and there is no timeout.
  - When the beat with cnt=BURST_LEN-1 is stored: wr_done=1 on the next cycle and the state returns to IDLE.
  - A 1-beat burst (BURST_LEN=1) goes IDLE→IDLE with wr_done pulsed.
- RD_WAIT:
  - The latency counter decrements each cycle.
  - At 0, go to RD_BURST with the synchronous read of mem[base] issued.
- RD_BURST:
  - Each cycle: r_data<=mem[base+cnt]; rdata_vaild<=1; cnt++.
  - After BURST_LEN beats, rdata_vaild falls and the state returns to IDLE.
  - The burst cannot be stalled.
- Read timing: read burstbegin sampled at edge k → rdata_vaild high after edges k+RD_LAT … k+RD_LAT+BURST_LEN-1.
- ready=0 in WR_BURST, RD_WAIT and RD_BURST. ready=1 is driven combinationally from state==IDLE.
- burstbegin while not IDLE: ignored, proto_err<=1, and the current burst continues unchanged.
- Back-to-back bursts:
  - A new burstbegin is accepted in the first IDLE cycle after a burst ends, i.e. the cycle where ready returns to 1.
  - Minimum gap between the last write beat and the next burstbegin is 1 cycle.
- Single-port ordering makes read-after-write coherent: a read accepted after wr_done returns the newly written data.
- Reset mid-burst:
  - The burst is aborted immediately and rdata_vaild drops asynchronously.
  - Already-written beats remain in memory; unwritten beats are lost.
- Widths: cnt is log2(BURST_LEN)+1 bits; the address sum is truncated to ADDR_W bits.

Test Plan:
1. Write burst at addr 0x000 with data 0x1000..0x1007 and no stalls, then a read burst at 0x000 with burstbegin at edge k → wr_done pulses once; rdata_vaild is high on edges k+2..k+9 with r_data 0x1000..0x1007 in order; ready returns to 1 after edge k+9.
2. Write at 0x3FC with data 0xA0..0xA7, then read at 0x000 → array holds 0x3FC..0x3FF=A0..A3 and 0x000..0x003=A4..A7; the read returns A4,A5,A6,A7 first.
3. Write burst with write_req low for 3 cycles after beat 3 → exactly 8 words are stored at base..base+7; wr_done arrives 3 cycles later than the unstalled case; ready stays 0 throughout.
4. burstbegin with write_req=read_req=1 at addr 0x040 → a write burst executes, no rdata_vaild occurs, proto_err=1 and stays 1.
5. Read burstbegin at addr 0x100 issued during an active read of 0x000 → the request is ignored, only the 8 beats of 0x000 are returned, proto_err=1.
6. reset_syn pulsed at read beat 4 → rdata_vaild goes to 0 immediately; after release ready=1 and proto_err=0; a new read of the same address returns all 8 beats intact.
